// File: rtl/pipeline_hazard_unit_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the pipeline hazard/forwarding logic:
//   - REG_ADDR_W_DEFAULT : default register address width
//   - FWD_REGFILE/FWD_MEM/FWD_WB : EX operand forward-select encodings
//   - tracker_entry_t    : one in-flight instruction record in the tracker
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int REG_ADDR_W_DEFAULT = 5;

    // Forward-select encodings: value k selects the result held in stage EX+k.
    localparam int FWD_REGFILE = 0;
    localparam int FWD_MEM     = 1;
    localparam int FWD_WB      = 2;

    // The rd field is sized by the package default; units instantiating the
    // tracker are expected to use the same register address width.
    typedef struct packed {
        logic                          valid;
        logic [REG_ADDR_W_DEFAULT-1:0] rd;
        logic                          reg_write;
        logic                          mem_read;
    } tracker_entry_t;

endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_unit_if
// Bundle between the decode/core side (master) and the hazard unit (slave).
//   master drives: enable, id_* decode fields, ex_redirect
//   slave drives : stall, flush, ex_valid, fwd_sel_1/2, stall_count, flush_count
// -----------------------------------------------------------------------------
interface pipeline_hazard_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int SEL_W      = 2
);
    logic                  enable;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  ex_redirect;

    logic                  stall;
    logic                  flush;
    logic                  ex_valid;
    logic [SEL_W-1:0]      fwd_sel_1;
    logic [SEL_W-1:0]      fwd_sel_2;
    logic [31:0]           stall_count;
    logic [31:0]           flush_count;

    modport master (
        output enable, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_write, id_mem_read, ex_redirect,
        input  stall, flush, ex_valid, fwd_sel_1, fwd_sel_2,
               stall_count, flush_count
    );

    modport slave (
        input  enable, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_write, id_mem_read, ex_redirect,
        output stall, flush, ex_valid, fwd_sel_1, fwd_sel_2,
               stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_unit_match.sv
// -----------------------------------------------------------------------------
// hazard_match
// Combinational compare of one EX source register against the producer
// entries EX+1..EX+FWD_DEPTH. Returns the index of the youngest matching
// producer, or FWD_REGFILE when none matches.
//   src, use_src : EX source register and its "is read" bit
//   stage        : tracker entries 1..FWD_DEPTH
//   sel          : forward select
// -----------------------------------------------------------------------------
module hazard_match
    import cpu_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT,
    parameter int FWD_DEPTH  = 2,
    parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  use_src,
    input  tracker_entry_t        stage [1:FWD_DEPTH],
    output logic [SEL_W-1:0]      sel
);

    // Scan oldest to youngest so the youngest match is the one left standing.
    // NOTE: sel gets its default before the loop; any path that skipped the
    // assignment would infer a latch.
    always_comb begin
        sel = SEL_W'(FWD_REGFILE);
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (use_src && stage[k].valid && stage[k].reg_write &&
                stage[k].rd != '0 && stage[k].rd == src) begin
                sel = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_unit
// Tracks destination registers in flight from EX to the last forwarding stage,
// drives EX operand forward selects, detects load-use hazards (stall IF/ID,
// bubble into ID/EX) and squashes IF/ID and ID/EX on an EX redirect.
//   clk, rst : core clock, synchronous active-high reset
//   bus      : pipeline_hazard_unit_if.slave (decode inputs, hazard outputs)
// Optional feature macro: PIPELINE_HAZARD_PERF_EN enables the 32-bit stall and
// flush performance counters; without it both counter outputs read 0.
// -----------------------------------------------------------------------------
module pipeline_hazard_unit
    import cpu_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT,
    parameter int FWD_DEPTH  = 2,
    parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_unit_if.slave  bus
);

    // Entry 0 is the EX slot; entry k is stage EX+k.
    tracker_entry_t        tracker   [0:FWD_DEPTH];
    tracker_entry_t        fwd_stage [1:FWD_DEPTH];
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic                  ex_use_rs1;
    logic                  ex_use_rs2;

    tracker_entry_t        load_entry;
    logic                  load_use_rs1;
    logic                  load_use_rs2;
    logic                  load_hit;
    logic                  stall;
    logic                  flush;

    // True when entry e is a live load whose rd is read by the ID instruction.
    function automatic logic reads_load(
        input tracker_entry_t        e,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic [REG_ADDR_W-1:0] rs2,
        input logic                  use1,
        input logic                  use2
    );
        return e.valid && e.mem_read && e.reg_write && (e.rd != '0) &&
               ((use1 && e.rd == rs1) || (use2 && e.rd == rs2));
    endfunction

    assign flush = tracker[0].valid & bus.ex_redirect;

    // Load data is never forwarded from MEM. With only MEM forwarding
    // available, the consumer also has to wait while the load sits in MEM.
    always_comb begin
        load_hit = reads_load(tracker[0], bus.id_rs1, bus.id_rs2,
                              bus.id_use_rs1, bus.id_use_rs2);
        if (FWD_DEPTH < FWD_WB) begin
            load_hit = load_hit |
                       reads_load(tracker[FWD_MEM], bus.id_rs1, bus.id_rs2,
                                  bus.id_use_rs1, bus.id_use_rs2);
        end
    end

    // Flush wins over stall: the stalled consumer is being squashed anyway.
    assign stall = bus.id_valid & load_hit & ~flush;

    // What enters EX on the next advance: a bubble on flush/stall, else ID.
    always_comb begin
        load_entry   = '0;
        load_use_rs1 = 1'b0;
        load_use_rs2 = 1'b0;
        if (!(flush || stall)) begin
            load_entry.valid     = bus.id_valid;
            load_entry.rd        = bus.id_rd;
            load_entry.reg_write = bus.id_reg_write;
            load_entry.mem_read  = bus.id_mem_read;
            load_use_rs1         = bus.id_valid & bus.id_use_rs1;
            load_use_rs2         = bus.id_valid & bus.id_use_rs2;
        end
    end

    // NOTE: state updates use non-blocking assignments so every entry shifts
    // from its pre-edge value regardless of statement order.
    // NOTE: the tracker is a handful of flops, not a RAM, so clearing every
    // entry on reset is cheap and keeps stale rd fields out of simulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= FWD_DEPTH; k++) begin
                tracker[k] <= '0;
            end
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_use_rs1 <= 1'b0;
            ex_use_rs2 <= 1'b0;
        end else if (bus.enable) begin
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                tracker[k] <= tracker[k-1];
            end
            tracker[0] <= load_entry;
            ex_rs1     <= bus.id_rs1;
            ex_rs2     <= bus.id_rs2;
            ex_use_rs1 <= load_use_rs1;
            ex_use_rs2 <= load_use_rs2;
        end
    end

    always_comb begin
        for (int k = 1; k <= FWD_DEPTH; k++) begin
            fwd_stage[k] = tracker[k];
        end
    end

    hazard_match #(
        .REG_ADDR_W (REG_ADDR_W),
        .FWD_DEPTH  (FWD_DEPTH),
        .SEL_W      (SEL_W)
    ) u_match_1 (
        .src     (ex_rs1),
        .use_src (ex_use_rs1),
        .stage   (fwd_stage),
        .sel     (bus.fwd_sel_1)
    );

    hazard_match #(
        .REG_ADDR_W (REG_ADDR_W),
        .FWD_DEPTH  (FWD_DEPTH),
        .SEL_W      (SEL_W)
    ) u_match_2 (
        .src     (ex_rs2),
        .use_src (ex_use_rs2),
        .stage   (fwd_stage),
        .sel     (bus.fwd_sel_2)
    );

    assign bus.stall    = stall;
    assign bus.flush    = flush;
    assign bus.ex_valid = tracker[0].valid;

`ifdef PIPELINE_HAZARD_PERF_EN
    logic [31:0] stall_count_q;
    logic [31:0] flush_count_q;

    // Counters wrap naturally at 32 bits; frozen cycles are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else if (bus.enable) begin
            if (stall) stall_count_q <= stall_count_q + 32'd1;
            if (flush) flush_count_q <= flush_count_q + 32'd1;
        end
    end

    assign bus.stall_count = stall_count_q;
    assign bus.flush_count = flush_count_q;
`else
    assign bus.stall_count = '0;
    assign bus.flush_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_unit
// Directed self-checking bench for pipeline_hazard_unit (FWD_DEPTH = 2).
// Inputs change 1 time unit after the rising edge; outputs are compared one
// further time unit later, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_unit;

    localparam int REG_ADDR_W = 5;
    localparam int FWD_DEPTH  = 2;
    localparam int SEL_W      = 2;

`ifdef PIPELINE_HAZARD_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    pipeline_hazard_unit_if #(.REG_ADDR_W(REG_ADDR_W), .SEL_W(SEL_W)) bus ();

    pipeline_hazard_unit #(
        .REG_ADDR_W (REG_ADDR_W),
        .FWD_DEPTH  (FWD_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic wr,
                          input logic mem);
        bus.id_valid     = v;
        bus.id_rs1       = rs1;
        bus.id_use_rs1   = u1;
        bus.id_rs2       = rs2;
        bus.id_use_rs2   = u2;
        bus.id_rd        = rd;
        bus.id_reg_write = wr;
        bus.id_mem_read  = mem;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Empty the tracker by clocking bubbles through every entry.
    task automatic drain();
        idle();
        bus.ex_redirect = 1'b0;
        repeat (FWD_DEPTH + 1) tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst             = 1'b1;
        bus.enable      = 1'b1;
        bus.ex_redirect = 1'b0;
        idle();

        // Reset state
        tick();
        tick();
        #1;
        check("rst_stall",    32'(bus.stall),     32'd0);
        check("rst_flush",    32'(bus.flush),     32'd0);
        check("rst_ex_valid", 32'(bus.ex_valid),  32'd0);
        check("rst_fwd1",     32'(bus.fwd_sel_1), 32'd0);
        check("rst_fwd2",     32'(bus.fwd_sel_2), 32'd0);
        check("rst_scount",   bus.stall_count,    32'd0);
        check("rst_fcount",   bus.flush_count,    32'd0);
        rst = 1'b0;

        // Back-to-back: add x5,x1,x2 ; sub x6,x5,x1
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        #1 check("b2b_id_stall", 32'(bus.stall), 32'd0);
        tick();
        set_id(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
        #1 check("b2b_prod_ex", 32'(bus.ex_valid), 32'd1);
        check("b2b_no_stall", 32'(bus.stall), 32'd0);
        tick();
        idle();
        #1 check("b2b_fwd1", 32'(bus.fwd_sel_1), 32'd1);
        check("b2b_fwd2", 32'(bus.fwd_sel_2), 32'd0);
        check("b2b_stall", 32'(bus.stall), 32'd0);
        drain();

        // Producer two ahead: add x5 ; nop ; or x7,x5,x5
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        tick();
        set_id(1, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0);
        tick();
        set_id(1, 5'd5, 1, 5'd5, 1, 5'd7, 1, 0);
        tick();
        idle();
        #1 check("two_fwd1", 32'(bus.fwd_sel_1), 32'd2);
        check("two_fwd2", 32'(bus.fwd_sel_2), 32'd2);
        drain();

        // Youngest wins: add x3 ; addi x3 ; addi x9,x3 (rs2=x3 but unused)
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0);
        tick();
        set_id(1, 5'd3, 1, 5'd0, 0, 5'd3, 1, 0);
        tick();
        set_id(1, 5'd3, 1, 5'd3, 0, 5'd9, 1, 0);
        tick();
        idle();
        #1 check("young_fwd1", 32'(bus.fwd_sel_1), 32'd1);
        check("young_fwd2_unused", 32'(bus.fwd_sel_2), 32'd0);
        drain();

        // Load-use: ld x4,0(x10) ; add x8,x4,x2
        set_id(1, 5'd10, 1, 5'd0, 0, 5'd4, 1, 1);
        #1 check("lu_no_stall_yet", 32'(bus.stall), 32'd0);
        tick();
        set_id(1, 5'd4, 1, 5'd2, 1, 5'd8, 1, 0);
        #1 check("lu_stall", 32'(bus.stall), 32'd1);
        check("lu_no_flush", 32'(bus.flush), 32'd0);
        tick();
        #1 check("lu_stall_done", 32'(bus.stall), 32'd0);
        check("lu_bubble", 32'(bus.ex_valid), 32'd0);
        tick();
        idle();
        #1 check("lu_consumer_ex", 32'(bus.ex_valid), 32'd1);
        check("lu_fwd1", 32'(bus.fwd_sel_1), 32'd2);
        check("lu_fwd2", 32'(bus.fwd_sel_2), 32'd0);
        check("lu_scount", bus.stall_count, 32'(PERF * 1));
        drain();

        // Writes to x0: addi x0 then read x0; also a load into x0
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 0);
        tick();
        set_id(1, 5'd0, 1, 5'd0, 1, 5'd7, 1, 0);
        #1 check("x0_no_stall", 32'(bus.stall), 32'd0);
        tick();
        idle();
        #1 check("x0_fwd1", 32'(bus.fwd_sel_1), 32'd0);
        check("x0_fwd2", 32'(bus.fwd_sel_2), 32'd0);
        drain();
        set_id(1, 5'd10, 1, 5'd0, 0, 5'd0, 1, 1);
        tick();
        set_id(1, 5'd0, 1, 5'd0, 1, 5'd7, 1, 0);
        #1 check("x0_load_no_stall", 32'(bus.stall), 32'd0);
        drain();

        // Redirect during load-use: flush wins, two EX bubbles follow
        set_id(1, 5'd10, 1, 5'd0, 0, 5'd4, 1, 1);
        tick();
        set_id(1, 5'd4, 1, 5'd2, 1, 5'd8, 1, 0);
        bus.ex_redirect = 1'b1;
        #1 check("rd_flush", 32'(bus.flush), 32'd1);
        check("rd_stall_masked", 32'(bus.stall), 32'd0);
        tick();
        bus.ex_redirect = 1'b0;
        idle();
        #1 check("rd_bubble1", 32'(bus.ex_valid), 32'd0);
        check("rd_flush_off", 32'(bus.flush), 32'd0);
        tick();
        #1 check("rd_bubble2", 32'(bus.ex_valid), 32'd0);
        check("rd_fcount", bus.flush_count, 32'(PERF * 1));
        drain();

        // enable=0 freezes state while stall is still reported
        set_id(1, 5'd10, 1, 5'd0, 0, 5'd4, 1, 1);
        tick();
        set_id(1, 5'd4, 1, 5'd2, 1, 5'd8, 1, 0);
        bus.enable = 1'b0;
        tick();
        tick();
        #1 check("en0_stall_held", 32'(bus.stall), 32'd1);
        check("en0_ex_valid", 32'(bus.ex_valid), 32'd1);
        check("en0_scount", bus.stall_count, 32'(PERF * 1));
        bus.enable = 1'b1;
        tick();
        #1 check("en1_stall_done", 32'(bus.stall), 32'd0);
        check("en1_bubble", 32'(bus.ex_valid), 32'd0);
        check("en1_scount", bus.stall_count, 32'(PERF * 2));
        drain();

        // Reset in the middle of a load-use stall
        set_id(1, 5'd10, 1, 5'd0, 0, 5'd4, 1, 1);
        tick();
        set_id(1, 5'd4, 1, 5'd2, 1, 5'd8, 1, 0);
        #1 check("rs_pre_stall", 32'(bus.stall), 32'd1);
        rst = 1'b1;
        tick();
        #1 check("rs_stall", 32'(bus.stall), 32'd0);
        check("rs_ex_valid", 32'(bus.ex_valid), 32'd0);
        check("rs_fwd1", 32'(bus.fwd_sel_1), 32'd0);
        check("rs_scount", bus.stall_count, 32'd0);
        check("rs_fcount", bus.flush_count, 32'd0);
        rst = 1'b0;
        tick();
        #1 check("rs_no_resume", 32'(bus.stall), 32'd0);
        check("rs_consumer_in", 32'(bus.ex_valid), 32'd1);
        drain();

        // Reset in the middle of a flush
        set_id(1, 5'd10, 1, 5'd0, 0, 5'd4, 1, 1);
        tick();
        set_id(1, 5'd4, 1, 5'd2, 1, 5'd8, 1, 0);
        bus.ex_redirect = 1'b1;
        #1 check("rf_pre_flush", 32'(bus.flush), 32'd1);
        rst = 1'b1;
        tick();
        #1 check("rf_flush", 32'(bus.flush), 32'd0);
        check("rf_stall", 32'(bus.stall), 32'd0);
        check("rf_ex_valid", 32'(bus.ex_valid), 32'd0);
        check("rf_fwd2", 32'(bus.fwd_sel_2), 32'd0);
        rst = 1'b0;
        bus.ex_redirect = 1'b0;
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
